// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, mid-bit sampling, LSB first; optional parity stage via RX_PARITY_EN
module uart_rx #(
    parameter int BPS_MAX    = 5208,
    parameter int BIT_MAX    = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [BIT_MAX-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic               parity_err,
    output logic               busy
);
    localparam int CW = $clog2(BPS_MAX + 1);
    localparam int BW = $clog2(BIT_MAX + 1);
    localparam logic [CW-1:0] HALF     = CW'(BPS_MAX / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_MAX - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_MAX - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t             state, state_nx;
    logic               rx_s1, rx_s, rx_d;
    logic [CW-1:0]      bps_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [BIT_MAX-1:0] shift;
    logic [BIT_MAX-1:0] data_q;
    logic               mid, last, stop_mid;

    assign mid      = (bps_cnt == HALF);
    assign last     = (bps_cnt == CNT_LAST);
    // Strobes are decoded straight from the stop-bit midpoint; reset suppresses them
    assign stop_mid = (state == STOP) && mid && !rst;
    assign rx_valid  = stop_mid && rx_s;
    assign frame_err = stop_mid && !rx_s;
    assign busy      = (state != IDLE);
    // The word is visible in the same cycle as its strobe, then held in data_q
    assign rx_data   = rx_valid ? shift : data_q;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s  <= rx_s1;
            rx_d  <= rx_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; START aborts if the line is high again at its midpoint
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_d && !rx_s) state_nx = START;
            START:   if (mid && rx_s) state_nx = IDLE;
                     else if (last) state_nx = DATA;
            DATA:    if (last && bit_cnt == BIT_LAST) state_nx = AFTER_DATA;
            PARITY:  if (last) state_nx = STOP;
            STOP:    if (mid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and held output word
    always_ff @(posedge clk) begin
        if (rst) begin
            bps_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
        end else begin
            if (state == IDLE || state_nx == IDLE || last) bps_cnt <= '0;
            else                                           bps_cnt <= bps_cnt + CW'(1);

            if (state == START)
                bit_cnt <= '0;
            else if (state == DATA && last && bit_cnt != BIT_LAST)
                bit_cnt <= bit_cnt + BW'(1);

            if (state == DATA && mid) begin
                for (int i = 0; i < BIT_MAX; i++) begin
                    if (bit_cnt == BW'(i)) shift[i] <= rx_s;
                end
            end

            if (rx_valid) data_q <= shift;
        end
    end

`ifdef RX_PARITY_EN
    logic par_bad;

    // Latch a parity mismatch at the parity-bit midpoint; reported with rx_valid
    always_ff @(posedge clk) begin
        if (rst)                        par_bad <= 1'b0;
        else if (state == PARITY && mid) par_bad <= (rx_s != ((^shift) ^ PARITY_ODD));
    end

    assign parity_err = rx_valid && par_bad;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_err = 1'b0;
`endif

endmodule
